// File: rtl/lzrw1_pkg.sv
// Shared types and format constants for the LZRW1 output packer.
// Item encoding, group geometry and the copy-item byte-pair encoder.
package lzrw1_pkg;

    localparam int GROUP_ITEMS = 16;
    localparam int OFFSET_W    = 12;
    localparam int BUF_BYTES   = 2 * GROUP_ITEMS;
    localparam int CTRL_W      = 16;
    localparam int IDX_W       = 5;
    localparam int WR_W        = 6;
    localparam int RD_W        = 5;

    localparam logic [3:0] MIN_LEN_M1 = 4'd2;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_CTRL_LO = 3'd1,
        ST_CTRL_HI = 3'd2,
        ST_ITEMS   = 3'd3,
        ST_FIN     = 3'd4
    } state_e;

    typedef struct packed {
        logic                is_copy;
        logic [7:0]          literal;
        logic [OFFSET_W-1:0] offset;
        logic [3:0]          len_m1;
    } item_t;

    // First byte carries offset[11:8] and the length code, second byte offset[7:0].
    function automatic logic [15:0] encode_copy(input logic [OFFSET_W-1:0] offset,
                                                input logic [3:0]          len_m1);
        return {offset[11:8], len_m1, offset[7:0]};
    endfunction

endpackage

// File: rtl/lzrw1_group_buf.sv
// Group byte buffer: single byte or byte-pair write, combinational single read.
// Latency: written data readable the cycle after the write; no flow control of its own.
module lzrw1_group_buf
    import lzrw1_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            wr_vld,
    input  logic            wr_pair,
    input  logic [RD_W-1:0] wr_addr,
    input  logic [15:0]     wr_dat,
    input  logic [RD_W-1:0] rd_addr,
    output logic [7:0]      rd_dat
);

    logic [7:0] mem_q [BUF_BYTES];
    logic [7:0] mem_d [BUF_BYTES];

    // High byte always lands at wr_addr; a pair also writes the low byte just after it.
    always_comb begin
        mem_d = mem_q;
        if (wr_vld) begin
            mem_d[wr_addr] = wr_dat[15:8];
            if (wr_pair) begin
                mem_d[wr_addr + RD_W'(1)] = wr_dat[7:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/lzrw1_out_packer.sv
// Packs literal/copy items into LZRW1 groups (16-bit control word + item bytes) and streams them out.
// Latency: first byte valid the cycle after a group closes; item_ready low while draining, out_data held on stall.
module lzrw1_out_packer
    import lzrw1_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                item_valid,
    output logic                item_ready,
    input  logic                item_is_copy,
    input  logic [7:0]          item_literal,
    input  logic [OFFSET_W-1:0] item_offset,
    input  logic [3:0]          item_len_m1,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic                out_last,
    output logic                done,
    output logic                err_len,
    output logic [15:0]         byte_count
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WR_W-1:0]   wr_q, wr_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              final_q, final_d;
    logic              err_len_q, err_len_d;
    logic [15:0]       byte_count_q, byte_count_d;
    logic              rdy_en_q, rdy_en_d;

    item_t       item;
    logic        item_acc;
    logic        flush_acc;
    logic        out_hs;
    logic        last_item;
    logic        buf_wr_vld;
    logic [15:0] buf_wr_dat;
    logic [7:0]  buf_rd_dat;

    assign item = {item_is_copy, item_literal, item_offset, item_len_m1};

    // rdy_en_q keeps item_ready low for the cycle following a reset edge.
    assign item_ready = (state_q == ST_COLLECT) && rdy_en_q;
    assign item_acc   = item_valid && item_ready;
    assign flush_acc  = flush && item_ready;
    assign out_valid  = (state_q == ST_CTRL_LO) || (state_q == ST_CTRL_HI) || (state_q == ST_ITEMS);
    assign out_hs     = out_valid && out_ready;
    assign last_item  = ({1'b0, rd_q} == (wr_q - WR_W'(1)));
    assign out_last   = (state_q == ST_ITEMS) && final_q && last_item;
    assign done       = (state_q == ST_FIN);
    assign err_len    = err_len_q;
    assign byte_count = byte_count_q;

    assign buf_wr_vld = item_acc;
    assign buf_wr_dat = item.is_copy ? encode_copy(item.offset, item.len_m1) : {item.literal, 8'h00};

    always_comb begin
        case (state_q)
            ST_CTRL_LO: out_data = ctrl_q[7:0];
            ST_CTRL_HI: out_data = ctrl_q[15:8];
            ST_ITEMS:   out_data = buf_rd_dat;
            default:    out_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        ctrl_d       = ctrl_q;
        final_d      = final_q;
        err_len_d    = err_len_q;
        byte_count_d = byte_count_q;
        rdy_en_d     = 1'b1;

        if (out_hs && (byte_count_q != 16'hFFFF)) begin
            byte_count_d = byte_count_q + 16'd1;
        end

        case (state_q)
            ST_COLLECT: begin
                if (item_acc) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (item.is_copy) begin
                        wr_d                = wr_q + WR_W'(2);
                        ctrl_d[idx_q[3:0]] = 1'b1;
                        if (item.len_m1 < MIN_LEN_M1) begin
                            err_len_d = 1'b1;
                        end
                    end else begin
                        wr_d = wr_q + WR_W'(1);
                    end
                end
                // A flush arriving with the 16th item still marks that full group final.
                if (idx_d == IDX_W'(GROUP_ITEMS)) begin
                    state_d = ST_CTRL_LO;
                    final_d = flush_acc;
                end else if (flush_acc) begin
                    state_d = (idx_d == '0) ? ST_FIN : ST_CTRL_LO;
                    final_d = 1'b1;
                end
            end
            ST_CTRL_LO: begin
                if (out_ready) state_d = ST_CTRL_HI;
            end
            ST_CTRL_HI: begin
                if (out_ready) state_d = ST_ITEMS;
            end
            ST_ITEMS: begin
                if (out_ready) begin
                    rd_d = rd_q + RD_W'(1);
                    if (last_item) begin
                        state_d = final_q ? ST_FIN : ST_COLLECT;
                        idx_d   = '0;
                        wr_d    = '0;
                        rd_d    = '0;
                        ctrl_d  = '0;
                        final_d = 1'b0;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_COLLECT;
                idx_d   = '0;
                wr_d    = '0;
                rd_d    = '0;
                ctrl_d  = '0;
                final_d = 1'b0;
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_COLLECT;
            idx_q        <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            ctrl_q       <= '0;
            final_q      <= 1'b0;
            err_len_q    <= 1'b0;
            byte_count_q <= '0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            ctrl_q       <= ctrl_d;
            final_q      <= final_d;
            err_len_q    <= err_len_d;
            byte_count_q <= byte_count_d;
            rdy_en_q     <= rdy_en_d;
        end
    end

    lzrw1_group_buf u_group_buf (
        .clock   (clock),
        .reset   (reset),
        .wr_vld  (buf_wr_vld),
        .wr_pair (item.is_copy),
        .wr_addr (wr_q[RD_W-1:0]),
        .wr_dat  (buf_wr_dat),
        .rd_addr (rd_q),
        .rd_dat  (buf_rd_dat)
    );

endmodule

// File: tb/tb_lzrw1_out_packer.sv
// Randomized bench for lzrw1_out_packer against a group-level byte-stream model.
module tb_lzrw1_out_packer;

    logic        clock;
    logic        reset;
    logic        item_valid;
    logic        item_ready;
    logic        item_is_copy;
    logic [7:0]  item_literal;
    logic [11:0] item_offset;
    logic [3:0]  item_len_m1;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        done;
    logic        err_len;
    logic [15:0] byte_count;

    lzrw1_out_packer dut (
        .clock        (clock),
        .reset        (reset),
        .item_valid   (item_valid),
        .item_ready   (item_ready),
        .item_is_copy (item_is_copy),
        .item_literal (item_literal),
        .item_offset  (item_offset),
        .item_len_m1  (item_len_m1),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .done         (done),
        .err_len      (err_len),
        .byte_count   (byte_count)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: current open group plus expected output stream.
    logic [15:0] m_ctrl = '0;
    int          m_cnt = 0;
    logic [7:0]  m_bytes[$];
    logic [7:0]  exp_dat[$];
    bit          exp_last[$];
    int          exp_done_cnt = 0;
    int          bc_exp = 0;
    bit          err_exp = 1'b0;

    logic [7:0]  got_dat[$];
    bit          got_last[$];
    int          done_cnt = 0;
    int          rdy_mode = 0;

    bit          prev_stall = 1'b0;
    logic [7:0]  prev_dat = '0;
    bit          prev_lastv = 1'b0;
    bit          prev_last_hs = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_vld",  32'(out_valid), 32'd1);
                check("stall_dat",  32'(out_data),  32'(prev_dat));
                check("stall_last", 32'(out_last),  32'(prev_lastv));
            end
            if (prev_last_hs) check("done_after_last", 32'(done), 32'd1);
            if (out_valid) check("no_overlap", 32'(item_ready), 32'd0);
            if (out_valid && out_ready) begin
                got_dat.push_back(out_data);
                got_last.push_back(out_last);
            end
            if (done) done_cnt++;
            prev_stall   = out_valid && !out_ready;
            prev_dat     = out_data;
            prev_lastv   = out_last;
            prev_last_hs = out_valid && out_ready && out_last;
        end
    end

    task automatic emit_group(input bit fin);
        exp_dat.push_back(m_ctrl[7:0]);  exp_last.push_back(1'b0);
        exp_dat.push_back(m_ctrl[15:8]); exp_last.push_back(1'b0);
        for (int i = 0; i < m_bytes.size(); i++) begin
            exp_dat.push_back(m_bytes[i]);
            exp_last.push_back(fin && (i == m_bytes.size() - 1));
        end
        bc_exp += 2 + m_bytes.size();
        m_ctrl = '0;
        m_cnt  = 0;
        m_bytes.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_item(input bit c, input logic [7:0] lit, input logic [11:0] off,
                             input logic [3:0] len, input bit fl);
        int t;
        t = 0;
        item_valid = 1'b1; item_is_copy = c; item_literal = lit;
        item_offset = off; item_len_m1 = len; flush = fl;
        @(negedge clock);
        while (!item_ready && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check("send_rdy", 32'(item_ready), 32'd1);
        @(posedge clock);
        #1;
        item_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic send_flush();
        int t;
        t = 0;
        flush = 1'b1;
        @(negedge clock);
        while (!item_ready && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check("flush_rdy", 32'(item_ready), 32'd1);
        @(posedge clock);
        #1;
        flush = 1'b0;
    endtask

    task automatic add_item(input bit c, input logic [7:0] lit, input logic [11:0] off,
                            input logic [3:0] len, input bit fl);
        if (c) begin
            m_ctrl[m_cnt] = 1'b1;
            m_bytes.push_back({off[11:8], len});
            m_bytes.push_back(off[7:0]);
            if (len < 4'd2) err_exp = 1'b1;
        end else begin
            m_bytes.push_back(lit);
        end
        m_cnt++;
        send_item(c, lit, off, len, fl);
        if (m_cnt == 16 || fl) emit_group(fl);
        if (fl) exp_done_cnt++;
    endtask

    task automatic flush_now();
        if (m_cnt > 0) emit_group(1'b1);
        send_flush();
        exp_done_cnt++;
    endtask

    task automatic clear_model();
        m_ctrl = '0; m_cnt = 0; m_bytes.delete();
        exp_dat.delete(); exp_last.delete(); got_dat.delete(); got_last.delete();
        exp_done_cnt = 0; done_cnt = 0;
    endtask

    task automatic drain_check(input string tag);
        int t;
        int n;
        t = 0;
        while ((got_dat.size() < exp_dat.size() || done_cnt < exp_done_cnt) && t < 5000) begin
            @(negedge clock);
            t++;
        end
        repeat (4) @(posedge clock);
        #1;
        check({tag, "_nbytes"}, 32'(got_dat.size()), 32'(exp_dat.size()));
        n = (got_dat.size() < exp_dat.size()) ? got_dat.size() : exp_dat.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_dat%0d", tag, i),  32'(got_dat[i]),  32'(exp_dat[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(exp_last[i]));
        end
        check({tag, "_done"},    32'(done_cnt),   32'(exp_done_cnt));
        check({tag, "_bcount"},  32'(byte_count), 32'(bc_exp));
        check({tag, "_errlen"},  32'(err_len),    32'(err_exp));
        check({tag, "_idle_rdy"}, 32'(item_ready), 32'd1);
        clear_model();
    endtask

    initial begin
        int  n;
        bit  fwl;
        bit  c;
        logic [7:0]  lit;
        logic [11:0] off;
        logic [3:0]  len;

        reset = 1'b1; item_valid = 1'b0; item_is_copy = 1'b0; item_literal = '0;
        item_offset = '0; item_len_m1 = '0; flush = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_item_ready", 32'(item_ready), 32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_data",   32'(out_data),   32'd0);
        check("rst_out_last",   32'(out_last),   32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_err_len",    32'(err_len),    32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_rst_ready", 32'(item_ready), 32'd1);

        // 16 literals, full group, no flush.
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) add_item(1'b0, 8'(8'h41 + i), 12'h0, 4'h0, 1'b0);
        check("first_vld_lat", 32'(out_valid), 32'd1);
        drain_check("lit16");

        // Literal + copy, then a separate flush.
        add_item(1'b0, 8'h61, 12'h000, 4'h0, 1'b0);
        add_item(1'b1, 8'h00, 12'hABC, 4'd5, 1'b0);
        flush_now();
        drain_check("lit_copy_flush");

        // 16 minimum-length copies: worst-case buffer fill.
        for (int i = 0; i < 16; i++) add_item(1'b1, 8'h00, 12'(i), 4'd2, 1'b0);
        drain_check("copy16");

        // Same 2-item group with flush on the last item and out_ready toggling.
        rdy_mode = 1;
        add_item(1'b0, 8'h61, 12'h000, 4'h0, 1'b0);
        add_item(1'b1, 8'h00, 12'hABC, 4'd5, 1'b1);
        drain_check("toggle_rdy");
        rdy_mode = 0;

        // Flush with an empty group: done only.
        flush_now();
        check("empty_done",     32'(done),      32'd1);
        check("empty_no_vld",   32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        check("empty_done_off", 32'(done),      32'd0);
        drain_check("empty_flush");

        // Illegal copy length: packed raw, err_len sticky.
        add_item(1'b1, 8'h00, 12'h123, 4'd1, 1'b0);
        flush_now();
        drain_check("errlen");
        add_item(1'b0, 8'h7E, 12'h000, 4'h0, 1'b1);
        drain_check("errlen_sticky");

        // Reset while streaming item bytes.
        for (int i = 0; i < 16; i++) add_item(1'b0, 8'($urandom), 12'h0, 4'h0, 1'b0);
        n = 0;
        while (got_dat.size() < 6 && n < 500) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_out_valid",  32'(out_valid),  32'd0);
        check("midrst_byte_count", 32'(byte_count), 32'd0);
        check("midrst_item_ready", 32'(item_ready), 32'd0);
        check("midrst_err_len",    32'(err_len),    32'd0);
        reset = 1'b0;
        clear_model();
        bc_exp = 0;
        err_exp = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 16; i++) add_item(1'b0, 8'($urandom), 12'h0, 4'h0, 1'b0);
        drain_check("post_midrst");

        // Random strings with random flush placement and backpressure.
        for (int s = 0; s < 10; s++) begin
            n   = $urandom_range(0, 40);
            fwl = 1'($urandom_range(0, 1));
            rdy_mode = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                c   = 1'($urandom_range(0, 1));
                lit = 8'($urandom);
                off = 12'($urandom);
                len = 4'($urandom_range(2, 15));
                add_item(c, lit, off, len, fwl && (i == n - 1));
            end
            if (!(fwl && n > 0)) flush_now();
            drain_check($sformatf("rnd%0d", s));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lzrw1_out_packer.md
Name: lzrw1_out_packer

Overview:
- Final stage of the LZRW1 compressor datapath. Sits downstream of the input/history stage and the match comparator.
- Accepts one item per handshake: either a literal byte or a copy item (12-bit offset, 4-bit length code). Packs items into LZRW1 groups of up to 16 items, each group preceded by a 16-bit control word.
- Buffers a whole group, then serialises it as a byte stream with valid/ready flow control. On flush it closes a partial group and marks the final byte.

Parameters:
GROUP_ITEMS, 16, items per group; equals control-word width; fixed by format.
OFFSET_W, 12, copy offset width; matches the 4096-byte history.
BUF_BYTES, 32, group buffer depth; 2*GROUP_ITEMS, worst case is all copies.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
item_valid  in  1  item present
item_ready  out  1  packer accepts item this cycle
item_is_copy  in  1  1 = copy item, 0 = literal
item_literal  in  8  literal byte; used when item_is_copy=0
item_offset  in  12  copy offset; used when item_is_copy=1
item_len_m1  in  4  match length minus 1; legal 2..15, i.e. lengths 3..16
flush  in  1  end of string; close current group
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts byte
out_data  out  8  compressed byte stream
out_last  out  1  with out_valid: final byte of the stream
done  out  1  one-cycle pulse after the final byte transfers
err_len  out  1  sticky; set when a copy arrives with item_len_m1<2
byte_count  out  16  total bytes emitted since reset; saturates at 0xFFFF

Behaviour:
- Clock/reset: one clock, named clock. Reset is synchronous and active-high, named reset. Reset has priority over all other inputs in the same cycle.
- Reset values: item_ready=0 in the reset cycle, then 1. out_valid=0, out_data=0, out_last=0, done=0, err_len=0, byte_count=0. Buffer, item count and control register all cleared.
- FSM states: COLLECT, CTRL_LO, CTRL_HI, ITEMS, FIN.
- COLLECT:
  - item_ready=1. An item is accepted when item_valid&item_ready.
  - Literal: write 1 byte at buf[wr]; wr+=1.
  - Copy: write buf[wr]={offset[11:8],len_m1} and buf[wr+1]=offset[7:0]; wr+=2; set ctrl[idx]=1.
  - idx increments per accepted item. Control bit i corresponds to the i-th item of the group.
  - When idx reaches 16: go to CTRL_LO next cycle. First out_valid comes 1 cycle after the 16th accept.
- Flush handling:
  - flush in COLLECT with idx>0: close group and go to CTRL_LO; the group is final. Unused control bits are 0.
  - flush together with an accepted item: the item is included first, then the group closes.
  - flush with idx=0 and no item accepted: go to FIN directly. No bytes are emitted; done pulses next cycle.
- CTRL_LO: out_data=ctrl[7:0]. Advance on out_ready.
- CTRL_HI: out_data=ctrl[15:8]. Advance on out_ready.
- ITEMS: out_data=buf[rd]. rd increments on each handshake. Leave after rd==wr-1 transfers.
  - Non-final group: return to COLLECT; clear idx, wr, rd, ctrl.
  - Final group: go to FIN.
- out_last: asserted only on the last ITEMS byte of the final group.
- FIN: done=1 for exactly one cycle, then COLLECT with everything cleared except byte_count and err_len.
- item_ready=0 in every state except COLLECT. There is no overlap between collection and draining.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_last hold stable.
- flush outside COLLECT: ignored. The upstream stage holds flush until item_ready=1.
- err_len: item is still packed with its raw len_m1 value. Flag stays set until reset.
- byte_count: increments on every out_valid&out_ready; saturates at 0xFFFF.
- Reset mid-emit: the partial group is discarded and out_valid drops the next cycle. No done pulse.

Decomposition:
- Package lzrw1_pkg:
  - typedef fsm state enum.
  - typedef packed struct item_t {is_copy, literal, offset, len_m1}.
  - Constants GROUP_ITEMS, CTRL_W=16, MIN_LEN_M1=2.
  - Function encode_copy(offset, len_m1) returning the 2-byte pair.
- Sub-module lzrw1_group_buf: 32x8 register file with byte/pair write port and single read port. The FSM and counters stay in the top module.

Test Plan:
- 16 literals 0x41..0x50, out_ready=1 -> bytes 0x00,0x00,0x41..0x50 (18 bytes); byte_count=18; no out_last.
- Items: literal 0x61, copy offset 0xABC len_m1 5, then flush -> bytes 0x02,0x00,0x61,0xA5,0xBC; out_last on 0xBC; done pulses next cycle.
- 16 copies (offset=i, len_m1=2) -> ctrl 0xFF,0xFF then 32 bytes {0x02,i}; item_ready=0 for all 34 transfers.
- Backpressure: toggle out_ready 1/0 each cycle during the 2-item flushed group -> identical byte sequence; out_data stable while stalled.
- flush with empty group -> no out_valid; done pulse 1 cycle later. Copy with len_m1=1 -> err_len=1 and sticky.
- reset asserted mid-ITEMS -> next cycle out_valid=0, byte_count=0, item_ready=0; then a fresh literal group packs correctly.
